// File: rtl/aes_block_tx.sv
// aes_block_tx: serialises one finished 128-bit ciphertext block as 16
// bytes into uart_tx, with a fixed inter-byte gap and a stall timeout.
module aes_block_tx #(
    parameter int GAP_CLKS     = 100,
    parameter int TIMEOUT_CLKS = 2048
) (
    input  logic         CLK10MHZ,
    input  logic         reset_n,
    input  logic         blk_valid,
    input  logic [0:127] blk_data,
    output logic         blk_ready,
    output logic         tx_dv,
    output logic [7:0]   tx_byte,
    input  logic         tx_done,
    output logic         busy,
    output logic [3:0]   byte_idx,
    output logic         done,
    output logic         err
);

    // A zero gap still spends one cycle in GAP so tx_dv never repeats.
    localparam int GAP_LEN = (GAP_CLKS < 1) ? 1 : GAP_CLKS;
    localparam int TW      = $clog2(TIMEOUT_CLKS + 1);
    localparam int GW      = $clog2(GAP_LEN + 1);

    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CLKS - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_GAP
    } state_t;

    state_t        state_q, state_d;
    logic [0:127]  hold_q, hold_d;
    logic [3:0]    idx_q, idx_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [GW-1:0] gcnt_q, gcnt_d;
    logic          dv_q, dv_d;
    logic [7:0]    byte_q, byte_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    assign blk_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign tx_dv     = dv_q;
    assign tx_byte   = byte_q;
    assign byte_idx  = idx_q;
    assign done      = done_q;
    assign err       = err_q;

    // Next-state logic; the byte register is loaded on every entry to SEND.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        tcnt_d  = tcnt_q;
        gcnt_d  = gcnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        dv_d    = 1'b0;
        byte_d  = byte_q;

        unique case (state_q)
            S_IDLE: begin
                if (blk_valid) begin
                    hold_d  = blk_data;
                    idx_d   = 4'd0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                tcnt_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                tcnt_d = tcnt_q + TW'(1);
                if (tx_done) begin
                    gcnt_d  = '0;
                    state_d = S_GAP;
                end else if (tcnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                gcnt_d = gcnt_q + GW'(1);
                if (gcnt_q == GAP_LAST) begin
                    if (idx_q == 4'd15) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = S_SEND;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_SEND) begin
            dv_d   = 1'b1;
            byte_d = hold_d[{idx_d, 3'b000} +: 8];
        end
    end

    // State and registered outputs; reset discards any partial block.
    always_ff @(posedge CLK10MHZ or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            hold_q  <= '0;
            idx_q   <= 4'd0;
            tcnt_q  <= '0;
            gcnt_q  <= '0;
            dv_q    <= 1'b0;
            byte_q  <= 8'h00;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            tcnt_q  <= tcnt_d;
            gcnt_q  <= gcnt_d;
            dv_q    <= dv_d;
            byte_q  <= byte_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: doc/aes_block_tx.md
# aes_block_tx

Downstream output stage of the AES-128 core: accepts one finished 128-bit ciphertext block through a valid/ready handshake and serialises it as 16 bytes into the existing `uart_tx` instance. It drives `uart_tx` through its `i_Tx_DV`/`i_Tx_Byte` inputs and consumes its `o_Tx_Done` output. It inserts a fixed inter-byte gap and aborts on a stalled transmitter. This replaces the ad-hoc transmit state inside the top-level controller.

## Interface
Parameters:
- `GAP_CLKS`, default 100: idle clocks inserted after each `tx_done` before the next byte (0 allowed).
- `TIMEOUT_CLKS`, default 2048: maximum clocks spent waiting for `tx_done` per byte before abort (must be ≥ 1).

Ports:
- `CLK10MHZ` in 1: single clock; all logic rising-edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `blk_valid` in 1: upstream block available.
- `blk_data` in 128 `[0:127]`: ciphertext block. Byte k = `blk_data[8k +: 8]`. Byte 0 (`[0:7]`) is sent first.
- `blk_ready` out 1: high only in IDLE.
- `tx_dv` out 1: one-cycle start pulse to `uart_tx.i_Tx_DV`.
- `tx_byte` out 8 `[7:0]`: byte to `uart_tx.i_Tx_Byte`; stable from the `tx_dv` cycle until the next load.
- `tx_done` in 1: `uart_tx.o_Tx_Done` pulse.
- `busy` out 1: high in every state except IDLE.
- `byte_idx` out 4: index of the byte currently in flight (0..15).
- `done` out 1: one-cycle pulse after byte 15's gap completes.
- `err` out 1: one-cycle pulse on timeout abort.

## Operation
States:
- **IDLE**
  - `blk_ready`=1.
  - On `blk_valid`&&`blk_ready`: capture `blk_data` into a 128-bit holding register, set `byte_idx`=0, go to SEND.
- **SEND** (exactly 1 cycle)
  - `tx_dv`=1; `tx_byte`=holding[8·`byte_idx` +: 8].
  - Clear the timeout counter; go to WAIT.
- **WAIT**
  - Timeout counter increments each cycle.
  - `tx_done`=1: go to GAP with the gap counter cleared.
  - Otherwise, counter reaches `TIMEOUT_CLKS`: pulse `err`, drop the block, go to IDLE.
  - `tx_done` and timeout in the same cycle: `tx_done` wins.
- **GAP**
  - Count `GAP_CLKS` cycles. If `GAP_CLKS`=0, leave after 1 cycle.
  - At the end: if `byte_idx`=15, pulse `done` and go to IDLE. Otherwise increment `byte_idx` and go to SEND.
- `tx_done` is ignored in IDLE, SEND and GAP (spurious or late pulses have no effect).
- `blk_valid` is ignored while `busy`; upstream must hold `blk_valid` and data until accepted.
- Counter widths are sized to hold `GAP_CLKS`/`TIMEOUT_CLKS` without wrap. `byte_idx` never exceeds 15.

## Timing
- Reset (asynchronous assert, synchronous-to-clock deassert is the upstream's job):
  - state IDLE
  - `blk_ready`=1
  - `tx_dv`=0, `tx_byte`=0
  - `busy`=0, `byte_idx`=0
  - `done`=0, `err`=0
  - holding register = 0
- Reset mid-block: immediate return to the above; the partial block is discarded; no `done`/`err`.
- Acceptance at edge N gives `tx_dv`=1 during cycle N+1 with byte 0 on `tx_byte`.
- Per-byte cost = 1 (SEND) + W (cycles until `tx_done`, inclusive) + max(`GAP_CLKS`,1).
- `done` asserts in the cycle after byte 15's last gap cycle. `blk_ready` rises in that same cycle; a new block may be accepted on that edge.
- `tx_dv` is never high for two consecutive cycles. Between `tx_dv` pulses there is at least 1 WAIT cycle plus 1 GAP cycle.
- All outputs are registered; no combinational path from inputs to outputs except none — `blk_ready` is derived from state only.

## Test plan
- Model `uart_tx` with `tx_done` pulsing 870 clocks after each `tx_dv`. Send block 3925841d02dc09fbdc118597196a0b32 → bytes 39,25,84,1d,02,dc,09,fb,dc,11,85,97,19,6a,0b,32 in order. Expect exactly 16 `tx_dv` pulses, `done` once, `err` never, and `byte_idx` stepping 0..15.
- Back-pressure: hold `blk_valid` with a second block during the first transfer. Expect `blk_ready`=0 throughout and the second block accepted in the `done` cycle, with its byte 0 `tx_dv` on the next cycle.
- Timeout with `TIMEOUT_CLKS`=50: never return `tx_done` on byte 3. Expect `err` exactly 50 cycles after byte 3's WAIT entry, then IDLE with no further `tx_dv` and no `done`.
- `GAP_CLKS`=0 with `tx_done` 1 cycle after `tx_dv`. Expect a `tx_dv` spacing of 3 cycles. Inject extra `tx_done` pulses in GAP/IDLE and expect no state change.
- Assert `reset_n`=0 during byte 7's WAIT. Expect all outputs at reset values immediately. A fresh block after release must start at byte 0.
